// File: rtl/hmmm_multicycle_core.sv
// HMMM multicycle core: FETCH/DECODE/EXEC/MEM/WB controller with req/ack instruction and data memories.
// Optional feature macro HMMM_OVF_TRAP_EN: signed ADD/SUB overflow halts the core instead of wrapping.
module hmmm_multicycle_core #(
    parameter  int DATA_W  = 4,
    parameter  int RA_W    = 2,
    parameter  int PC_W    = 8,
    localparam int INSTR_W = 4 + 3 * RA_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               retire,
    output logic               halted,
    output logic               illegal
);
    localparam int NREGS = 2 ** RA_W;
    localparam int IMM_W = 2 * RA_W;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_LOADI = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b0110;

    localparam logic [PC_W-1:0]   PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_next_r;
    logic [INSTR_W-1:0] ir_r;
    logic [DATA_W-1:0]  regs_r [NREGS];
    logic [DATA_W-1:0]  opd_r;
    logic [DATA_W-1:0]  opa_r;
    logic [DATA_W-1:0]  opb_r;
    logic [DATA_W-1:0]  res_r;
    logic               wr_en_r;
    logic               illegal_r;
    logic               imem_req_r;
    logic               dmem_req_r;
    logic               dmem_we_r;
    logic [DATA_W-1:0]  dmem_addr_r;
    logic [DATA_W-1:0]  dmem_wdata_r;
    logic               retire_r;
    logic               halted_r;

    logic [3:0]         funct_s;
    logic [RA_W-1:0]    rd_s;
    logic [RA_W-1:0]    ra_s;
    logic [RA_W-1:0]    rb_s;
    logic [IMM_W-1:0]   imm_s;
    logic [DATA_W-1:0]  sum_s;
    logic [DATA_W-1:0]  diff_s;
    logic [DATA_W-1:0]  alu_res_s;
    logic               writes_s;
    logic               taken_s;
    logic               illegal_op_s;

    // Branch offset is a signed immediate widened to the PC width.
    function automatic logic [PC_W-1:0] sext_off(input logic [IMM_W-1:0] imm);
        return PC_W'($signed(imm));
    endfunction

    assign funct_s = ir_r[INSTR_W-1 -: 4];
    assign rd_s    = ir_r[3*RA_W-1 -: RA_W];
    assign ra_s    = ir_r[2*RA_W-1 -: RA_W];
    assign rb_s    = ir_r[RA_W-1:0];
    assign imm_s   = ir_r[IMM_W-1:0];
    assign sum_s   = opa_r + opb_r;
    assign diff_s  = opa_r + ~opb_r + DATA_ONE;

`ifdef HMMM_OVF_TRAP_EN
    logic ovf_s;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    assign ovf_s = ((funct_s == OP_ADD) && add_ovf(opa_r[DATA_W-1], opb_r[DATA_W-1], sum_s[DATA_W-1])) ||
                   ((funct_s == OP_SUB) && add_ovf(opa_r[DATA_W-1], ~opb_r[DATA_W-1], diff_s[DATA_W-1]));
`endif

    // Execute stage: ALU result, rd write enable, branch decision, reserved-opcode detect.
    always_comb begin
        alu_res_s    = '0;
        writes_s     = 1'b0;
        taken_s      = 1'b0;
        illegal_op_s = 1'b0;
        casez (funct_s)
            OP_NOP: begin
                writes_s = 1'b0;
            end
            OP_ADD: begin
                alu_res_s = sum_s;
                writes_s  = 1'b1;
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                writes_s  = 1'b1;
            end
            OP_LOADI: begin
                alu_res_s = DATA_W'(imm_s);
                writes_s  = 1'b1;
            end
            OP_LOAD: begin
                writes_s = 1'b1;
            end
            OP_STORE, OP_HALT: begin
                writes_s = 1'b0;
            end
            4'b10??: begin
                case (funct_s[1:0])
                    2'b00:   taken_s = 1'b1;
                    2'b01:   taken_s = (opd_r == '0);
                    2'b10:   taken_s = opd_r[DATA_W-1];
                    2'b11:   taken_s = (opd_r != '0);
                    default: taken_s = 1'b0;
                endcase
            end
            default: begin
                illegal_op_s = 1'b1;
            end
        endcase
    end

    // Next-state logic of the instruction sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (imem_req_r && imem_ack) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: next_state_s = S_EXEC;
            S_EXEC: begin
                if ((funct_s == OP_LOAD) || (funct_s == OP_STORE)) begin
                    next_state_s = S_MEM;
                end else if (funct_s == OP_HALT) begin
                    next_state_s = S_HALT;
`ifdef HMMM_OVF_TRAP_EN
                end else if (ovf_s) begin
                    next_state_s = S_HALT;
`endif
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_req_r && dmem_ack) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB:    next_state_s = S_FETCH;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_FETCH;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: instruction latch, operand read, execute results; architectural state changes only in WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r      <= '0;
            pc_next_r <= '0;
            ir_r      <= '0;
            opd_r     <= '0;
            opa_r     <= '0;
            opb_r     <= '0;
            res_r     <= '0;
            wr_en_r   <= 1'b0;
            illegal_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (imem_req_r && imem_ack) begin
                        ir_r <= imem_rdata;
                    end
                end
                S_DECODE: begin
                    opd_r <= regs_r[rd_s];
                    opa_r <= regs_r[ra_s];
                    opb_r <= regs_r[rb_s];
                end
                S_EXEC: begin
                    res_r     <= alu_res_s;
                    wr_en_r   <= writes_s;
                    pc_next_r <= taken_s ? (pc_r + PC_ONE + sext_off(imm_s)) : (pc_r + PC_ONE);
                    illegal_r <= illegal_r | illegal_op_s;
                end
                S_MEM: begin
                    if (dmem_req_r && dmem_ack && !dmem_we_r) begin
                        res_r <= dmem_rdata;
                    end
                end
                S_WB: begin
                    if (wr_en_r) begin
                        regs_r[rd_s] <= res_r;
                    end
                    pc_r <= pc_next_r;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    // Handshake and status outputs, registered from the state being entered so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= '0;
            dmem_wdata_r <= '0;
            retire_r     <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            imem_req_r <= (next_state_s == S_FETCH);
            dmem_req_r <= (next_state_s == S_MEM);
            dmem_we_r  <= (next_state_s == S_MEM) && (funct_s == OP_STORE);
            retire_r   <= (next_state_s == S_WB);
            halted_r   <= (next_state_s == S_HALT);
            if (state_r == S_EXEC) begin
                dmem_addr_r  <= opa_r;
                dmem_wdata_r <= opd_r;
            end
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign retire     = retire_r;
    assign halted     = halted_r;
    assign illegal    = illegal_r;

endmodule

// File: tb/tb_hmmm_multicycle_core.sv
// Scoreboard bench for hmmm_multicycle_core: directed programs, expected fetch/data traffic queued, monitor compares.
module tb_hmmm_multicycle_core;
    localparam int DATA_W  = 4;
    localparam int RA_W    = 2;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 4 + 3 * RA_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic [DATA_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ack;
    logic [DATA_W-1:0]  dmem_rdata;
    logic               retire;
    logic               halted;
    logic               illegal;

    hmmm_multicycle_core #(.DATA_W(DATA_W), .RA_W(RA_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct { logic [PC_W-1:0] addr; int gap; } fetch_t;
    typedef struct { logic we; logic [DATA_W-1:0] addr; logic [DATA_W-1:0] wdata; int len; } dacc_t;

    fetch_t             fq[$];
    dacc_t              dq[$];
    logic [INSTR_W-1:0] imem [256];
    logic [DATA_W-1:0]  dmem [16];
    int                 checks = 0;
    int                 fails = 0;
    int                 retires = 0;
    int                 cyc = 0;

    function automatic logic [INSTR_W-1:0] enc(input logic [3:0] f, input logic [1:0] rd,
                                               input logic [1:0] ra, input logic [1:0] rb);
        return {f, rd, ra, rb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_fetch(input int a, input int g);
        fetch_t e;
        e.addr = PC_W'(a);
        e.gap  = g;
        fq.push_back(e);
    endtask

    task automatic exp_dmem(input logic we, input int a, input int d, input int len);
        dacc_t e;
        e.we    = we;
        e.addr  = DATA_W'(a);
        e.wdata = DATA_W'(d);
        e.len   = len;
        dq.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = enc(4'b0110, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 16; i++) dmem[i] = 4'h0;
    endtask

    task automatic check_reset(input string name);
        check(name, 32'({imem_req, dmem_req, dmem_we, retire, halted, illegal, imem_addr}), 32'd0);
    endtask

    // Instruction memory: zero-wait, answers in the first request cycle.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                imem_ack   = 1'b1;
                imem_rdata = imem[imem_addr];
            end else begin
                imem_ack = 1'b0;
            end
        end
    end

    // Data memory: stores to address 9 wait 3 extra cycles, everything else is zero-wait.
    initial begin
        int dcnt;
        int dwait;
        dcnt       = 0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (dmem_req && !reset) begin
                dwait = (dmem_we && dmem_addr == 4'd9) ? 3 : 0;
                if (dcnt == dwait) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = dmem[dmem_addr];
                end else begin
                    dmem_ack = 1'b0;
                end
                dcnt++;
            end else begin
                dmem_ack = 1'b0;
                dcnt     = 0;
            end
        end
    end

    // Monitor: pops expected fetches/data accesses as the DUT issues them.
    initial begin
        logic   iprev;
        logic   dprev;
        logic   dvalid;
        int     last_fetch;
        int     dlen;
        fetch_t fe;
        dacc_t  dcur;
        iprev = 1'b0; dprev = 1'b0; dvalid = 1'b0; last_fetch = 0; dlen = 0;
        dcur = '{1'b0, 4'h0, 4'h0, 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                iprev = 1'b0; dprev = 1'b0; dvalid = 1'b0; retires = 0;
            end else begin
                if (retire) retires++;
                if (imem_req && !iprev) begin
                    if (fq.size() > 0) begin
                        fe = fq.pop_front();
                        check("fetch_addr", 32'(imem_addr), 32'(fe.addr));
                        if (fe.gap != 0) check("fetch_gap", 32'(cyc - last_fetch), 32'(fe.gap));
                    end
                    last_fetch = cyc;
                end
                if (dmem_req && !dprev) begin
                    dlen = 1;
                    check("dmem_expected", 32'(dq.size() > 0), 32'd1);
                    dvalid = (dq.size() > 0);
                    if (dvalid) begin
                        dcur = dq.pop_front();
                        check("dmem_we", 32'(dmem_we), 32'(dcur.we));
                        check("dmem_addr", 32'(dmem_addr), 32'(dcur.addr));
                        if (dcur.we) check("dmem_wdata", 32'(dmem_wdata), 32'(dcur.wdata));
                    end
                end else if (dmem_req && dvalid) begin
                    dlen++;
                    check("dmem_stable", 32'({dmem_we, dmem_addr, dmem_wdata}),
                          32'({dcur.we, dcur.addr, dcur.we ? dcur.wdata : dmem_wdata}));
                end else if (!dmem_req && dprev && dvalid) begin
                    check("dmem_len", 32'(dlen), 32'(dcur.len));
                    dvalid = 1'b0;
                end
                iprev = imem_req;
                dprev = dmem_req;
            end
        end
    end

    task automatic run_phase(input string name, input bit exp_halt, input int exp_ret,
                             input int exp_pc, input bit exp_ill);
        int c;
        bit saw;
        check_reset({name, "_reset"});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c = 0;
        while ((fq.size() != 0 || dq.size() != 0) && c < 400) begin
            @(negedge clk); #1;
            c++;
        end
        check({name, "_pending"}, 32'(fq.size() + dq.size()), 32'd0);
        fq.delete();
        dq.delete();
        if (exp_halt) begin
            saw = 1'b0;
            repeat (12) begin
                @(negedge clk); #1;
                if (imem_req || dmem_req || retire) saw = 1'b1;
            end
            check({name, "_halted"}, 32'(halted), 32'd1);
            check({name, "_quiet"}, 32'(saw), 32'd0);
            check({name, "_halt_pc"}, 32'(imem_addr), 32'(exp_pc));
        end else begin
            c = 0;
            while (!imem_req && c < 10) begin
                @(negedge clk); #1;
                c++;
            end
            check({name, "_refetch"}, 32'(imem_req), 32'd1);
        end
        check({name, "_retires"}, 32'(retires), 32'(exp_ret));
        check({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
        reset = 1'b1;
        #1;
        check({name, "_req_drop"}, 32'({imem_req, dmem_req}), 32'd0);
    endtask

    int a_gap [14] = '{0, 4, 4, 4, 5, 4, 8, 5, 5, 4, 4, 4, 5, 4};
    int d_addr[6]  = '{0, 5, 8, 9, 5, 6};

    initial begin
        #1;
        // ALU, load/store with wait states, ADD 7+1, reserved opcode, HALT
        clear_mem();
        imem[0]  = enc(4'b0011, 2'd1, 2'd1, 2'd1);
        imem[1]  = enc(4'b0011, 2'd2, 2'd0, 2'd3);
        imem[2]  = enc(4'b0010, 2'd3, 2'd1, 2'd2);
        imem[3]  = enc(4'b0101, 2'd3, 2'd1, 2'd0);
        imem[4]  = enc(4'b0011, 2'd1, 2'd2, 2'd1);
        imem[5]  = enc(4'b0101, 2'd2, 2'd1, 2'd0);
        imem[6]  = enc(4'b0100, 2'd3, 2'd1, 2'd0);
        imem[7]  = enc(4'b0101, 2'd3, 2'd2, 2'd0);
        imem[8]  = enc(4'b0011, 2'd1, 2'd1, 2'd3);
        imem[9]  = enc(4'b0011, 2'd2, 2'd0, 2'd1);
        imem[10] = enc(4'b0001, 2'd3, 2'd1, 2'd2);
        imem[11] = enc(4'b0101, 2'd3, 2'd0, 2'd0);
        imem[12] = enc(4'b1100, 2'd0, 2'd0, 2'd0);
        imem[13] = enc(4'b0110, 2'd0, 2'd0, 2'd0);
        exp_dmem(1'b1, 5, 2, 1);
        exp_dmem(1'b1, 9, 3, 4);
        exp_dmem(1'b0, 9, 0, 1);
        exp_dmem(1'b1, 3, 3, 1);
`ifdef HMMM_OVF_TRAP_EN
        for (int i = 0; i < 11; i++) exp_fetch(i, a_gap[i]);
        run_phase("alu_mem", 1'b1, 10, 10, 1'b0);
`else
        for (int i = 0; i < 14; i++) exp_fetch(i, a_gap[i]);
        exp_dmem(1'b1, 0, 8, 1);
        run_phase("alu_mem", 1'b1, 13, 13, 1'b1);
`endif
        // backward branch from PC=1 to 0
        clear_mem();
        imem[1] = enc(4'b1000, 2'd0, 2'd3, 2'd2);
        imem[0] = enc(4'b0000, 2'd0, 2'd0, 2'd0);
        exp_fetch(0, 0); exp_fetch(1, 4); exp_fetch(0, 4);
        run_phase("br_back", 1'b0, 2, 0, 1'b0);
        // PC wrap 0 -> 255 -> 0
        clear_mem();
        imem[0]   = enc(4'b1000, 2'd0, 2'd3, 2'd2);
        imem[255] = enc(4'b1000, 2'd0, 2'd0, 2'd0);
        exp_fetch(0, 0); exp_fetch(255, 4); exp_fetch(0, 4);
        run_phase("br_wrap", 1'b0, 2, 0, 1'b0);
        // branch-zero taken (r1=0) then not taken (r1=1)
        clear_mem();
        imem[0] = enc(4'b1000, 2'd0, 2'd1, 2'd0);
        imem[5] = enc(4'b1001, 2'd1, 2'd0, 2'd2);
        imem[8] = enc(4'b0011, 2'd1, 2'd0, 2'd1);
        imem[9] = enc(4'b1000, 2'd0, 2'd2, 2'd3);
        imem[6] = enc(4'b0110, 2'd0, 2'd0, 2'd0);
        exp_fetch(d_addr[0], 0);
        for (int i = 1; i < 6; i++) exp_fetch(d_addr[i], 4);
        run_phase("br_zero", 1'b1, 5, 6, 1'b0);
        check_reset("final_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/hmmm_multicycle_core.md
Name: hmmm_multicycle_core

Overview:
Parametrised multicycle successor to the 4-bit single-cycle HMMM datapath/controller.
- Fetches one instruction per request over an instruction-memory handshake and runs it through a fixed FSM (FETCH/DECODE/EXEC/MEM/WB).
- Data width, register count and PC width are parameters.
- Adds data-memory load/store with req/ack, conditional PC-relative branches on zero/negative/nonzero, a halt state and an illegal-opcode flag.

Parameters:
DATA_W, 4, register/ALU/data-address width
RA_W, 2, register address width; NREGS = 2**RA_W
PC_W, 8, program counter width
INSTR_W, 4+3*RA_W, instruction width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  INSTR_W  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  DATA_W  data address
dmem_wdata  out  DATA_W  store data
dmem_ack  in  1  access complete / load data valid
dmem_rdata  in  DATA_W  load data
retire  out  1  one-cycle pulse when an instruction completes
halted  out  1  core in HALT state
illegal  out  1  sticky; set on reserved opcode

Behaviour:
Reset: clk with asynchronous active-high reset. While reset is high, all state clears immediately:
- PC=0, all registers=0, state=FETCH.
- imem_req=0, dmem_req=0, dmem_we=0, retire=0, halted=0, illegal=0.

Instruction format (MSB first): funct[3:0] | rd | ra | rb, each register field RA_W bits.
Immediate and offset: imm = {ra,rb}, 2*RA_W bits.

Opcodes:
- 0000 NOP.
- 0001 ADD: rd=ra+rb.
- 0010 SUB: rd=ra-rb.
- 0011 LOADI: rd=zero-extended imm (truncated if wider than DATA_W).
- 0100 LOAD: rd=mem[R[ra]].
- 0101 STORE: mem[R[ra]]=R[rd].
- 0110 HALT.
- 10tt BRANCH on R[rd], by tt:
  - 00 always.
  - 01 zero (R[rd]==0).
  - 10 negative (R[rd][DATA_W-1]).
  - 11 nonzero.
- Branch taken: PC = PC+1+sign-extended imm. Not taken: PC+1.
- 0111 and 11xx are reserved: execute as NOP and set illegal.

Arithmetic:
- All ADD/SUB results are modulo 2**DATA_W.
- SUB is implemented as a + ~b + 1.
- PC arithmetic is modulo 2**PC_W; wrap 2**PC_W-1 -> 0 is legal.

FSM:
- FETCH: imem_req=1, imem_addr=PC. Stays in FETCH until imem_ack; on ack latch imem_rdata and go to DECODE.
- DECODE: read R[rd], R[ra], R[rb]; go to EXEC.
- EXEC:
  - ALU result / branch decision.
  - LOAD or STORE -> MEM.
  - HALT -> HALT.
  - otherwise -> WB.
- MEM: dmem_req=1, dmem_addr=R[ra], dmem_we=1 for STORE, dmem_wdata=R[rd]. Outputs are held stable until dmem_ack; on ack go to WB (LOAD latches dmem_rdata).
- WB: write rd where applicable, update PC, retire=1 for this cycle; go to FETCH.
- HALT: halted=1, no requests, PC frozen at the HALT address. Leaves only via reset.

Latency (zero-wait memory, ack in first request cycle):
- ALU/branch/NOP: 4 cycles FETCH→WB.
- LOAD/STORE: 5 cycles.
- Each extra wait cycle adds 1.

Rules:
- imem_ack/dmem_ack are ignored when the corresponding req is low.
- Reset asserted mid-fetch or mid-MEM: request drops immediately and no write occurs.
- Register write and PC update happen only in WB.
- A branch whose rd is also ra/rb is read-only; no hazard, since only one instruction is in flight.

Optional Feature:
HMMM_OVF_TRAP_EN:
- Defined: signed overflow on ADD or SUB suppresses the rd write and transitions EXEC→HALT, with PC left at the faulting instruction. illegal is not set; halted=1.
- Undefined: overflow wraps silently; there is no trap path.

Test Plan:
- LOADI r1,5 (0011010101); LOADI r2,3 (0011100011); SUB r3,r1,r2 (0010110110) -> r3=2, three retire pulses, PC=3, zero-wait fetch spacing 4 cycles.
- r1=0; BRANCH-zero on r1, imm=4'b0010 at PC=5 -> next imem_addr=8. Repeat with r1=1 -> next imem_addr=6.
- BRANCH-always with imm=4'b1110 at PC=1 -> next imem_addr=0 (backward, 1+1-2). Same at PC=255 with imm=0 -> wraps to 0.
- STORE r2 to [r1=9], dmem_ack delayed 3 cycles -> dmem_req/addr=9/wdata/we=1 stable for 4 cycles; then LOAD r3 from [9] with dmem_rdata=3 -> r3=3.
- Opcode 1100 -> illegal=1 and stays set, PC advances by 1; HALT (0110000000) -> halted=1, imem_req=0 forever. Reset pulse -> halted=0, illegal=0, PC=0.
- ADD 7+1 with DATA_W=4: macro undefined -> rd=8 (0x8); macro defined -> rd unchanged, halted=1, PC at the ADD.
